// File: rtl/fas_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   MODE_*    : encoding of the a_ns mode bit
//   ovf_bit() : two's-complement overflow from operand/result sign bits
package fas_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b1;
   localparam logic MODE_SUB = 1'b0;

   // Add overflows when like-signed operands give a differently signed result;
   // subtract overflows when unlike-signed operands give a result whose sign differs from A.
   function automatic logic ovf_bit(input logic sa, input logic sb,
                                    input logic sr, input logic mode);
      logic same_sign;
      same_sign = (sa == sb);
      if (mode == MODE_ADD) begin
         ovf_bit = same_sign && (sr != sa);
      end else begin
         ovf_bit = !same_sign && (sr != sa);
      end
   endfunction

endpackage

// File: rtl/fas.sv
// Single-bit full adder/subtractor cell.
//   a, b, cin : operand bits and incoming carry/borrow
//   a_ns      : 1 = add, 0 = subtract (a - b)
//   s         : sum/difference bit
//   cout      : outgoing carry (add) or borrow (subtract)
module fas (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic s,
   output logic cout
);

   assign s = a ^ b ^ cin;

   // Borrow is the carry equation with a inverted.
   assign cout = a_ns ? ((a & b) | (a & cin) | (b & cin))
                      : ((~a & b) | (~a & cin) | (b & cin));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor around one fas cell, LSB first.
//   clk, rst         : clock (rising edge), async active-high reset
//   start, a_ns      : operation request and mode (1 = add, 0 = subtract)
//   a_in, b_in       : operands, sampled with an accepted start
//   busy             : high while bits are processed
//   done             : one-cycle pulse, result/cout/ovf valid
//   result, cout, ovf: sum/difference, final carry/borrow, signed overflow
module serial_addsub
   import fas_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             a_ns,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_mode;
   logic               r_carry;
   logic               r_sa;
   logic               r_sb;
   logic [WIDTH-1:0]   r_result;
   logic               r_cout;
   logic               r_ovf;
   logic               r_busy;
   logic               r_done;

   logic               w_s;
   logic               w_cout;
   logic               w_load;
   logic               w_last;

   // Start is only honoured when no operation is in flight.
   assign w_load = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

   fas u_fas (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .a_ns (r_mode),
      .s    (w_s),
      .cout (w_cout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? RUN : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Status flags registered from the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_next == RUN);
         r_done <= (w_state_next == DONE);
      end
   end

   // Operand load, serial datapath and final flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_mode   <= MODE_ADD;
         r_carry  <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_load) begin
         r_cnt   <= '0;
         r_a     <= a_in;
         r_b     <= b_in;
         r_mode  <= a_ns;
         r_carry <= 1'b0;
         r_sa    <= a_in[WIDTH-1];
         r_sb    <= b_in[WIDTH-1];
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == RUN) begin
         r_cnt    <= r_cnt + CNT_W'(1);
         r_a      <= {1'b0, r_a[WIDTH-1:1]};
         r_b      <= {1'b0, r_b[WIDTH-1:1]};
         r_carry  <= w_cout;
         r_result <= {w_s, r_result[WIDTH-1:1]};
         // On the last bit w_s is the result sign bit.
         if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= ovf_bit(r_sa, r_sb, w_s, r_mode);
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8).
module tb_serial_addsub;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             a_ns;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   int n_checks;
   int n_errors;

   serial_addsub #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a_ns   (a_ns),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive a start for one edge from the current point in the cycle.
   task automatic start_now(input logic mode, input logic [7:0] a, input logic [7:0] b);
      start = 1'b1;
      a_ns  = mode;
      a_in  = a;
      b_in  = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Start from a clean IDLE cycle.
   task automatic start_op(input logic mode, input logic [7:0] a, input logic [7:0] b);
      @(posedge clk);
      @(negedge clk);
      start_now(mode, a, b);
   endtask

   // Called in the first busy cycle; counts busy cycles, then checks the done cycle.
   // inject_at >= 0 drives a stray start (0xAA - 0x55) during that busy cycle.
   task automatic finish_op(input string tag, input logic [7:0] exp_r, input logic exp_c,
                            input logic exp_o, input int inject_at);
      int n;
      n = 0;
      check({tag, ".busy0"}, 32'(busy), 32'd1);
      while (busy && n < 40) begin
         if (n == inject_at) begin
            start = 1'b1; a_ns = 1'b0; a_in = 8'hAA; b_in = 8'h55;
         end
         n++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      check({tag, ".lat"},  32'(n),      32'd8);
      check({tag, ".done"}, 32'(done),   32'd1);
      check({tag, ".res"},  32'(result), 32'(exp_r));
      check({tag, ".cout"}, 32'(cout),   32'(exp_c));
      check({tag, ".ovf"},  32'(ovf),    32'(exp_o));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; start = 1'b0; a_ns = 1'b1; a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", 32'(busy),   32'd0);
      check("rst.done", 32'(done),   32'd0);
      check("rst.res",  32'(result), 32'd0);
      check("rst.cout", 32'(cout),   32'd0);
      check("rst.ovf",  32'(ovf),    32'd0);
      @(negedge clk); rst = 1'b0;

      // 1: basic add and latency
      start_op(1'b1, 8'h05, 8'h03); finish_op("add05_03", 8'h08, 1'b0, 1'b0, -1);
      @(posedge clk); #1;
      check("idle.done", 32'(done),   32'd0);
      check("idle.busy", 32'(busy),   32'd0);
      check("idle.res",  32'(result), 32'h08);

      // 2: carry out, signed overflow on add
      start_op(1'b1, 8'hFF, 8'h01); finish_op("addFF_01", 8'h00, 1'b1, 1'b0, -1);
      start_op(1'b1, 8'h7F, 8'h01); finish_op("add7F_01", 8'h80, 1'b0, 1'b1, -1);

      // 3: borrow, signed overflow on subtract
      start_op(1'b0, 8'h03, 8'h05); finish_op("sub03_05", 8'hFE, 1'b1, 1'b0, -1);
      start_op(1'b0, 8'h80, 8'h01); finish_op("sub80_01", 8'h7F, 1'b0, 1'b1, -1);
      start_op(1'b0, 8'h00, 8'h01); finish_op("sub00_01", 8'hFF, 1'b1, 1'b0, -1);

      // 4: start during RUN is ignored
      start_op(1'b1, 8'h12, 8'h34); finish_op("ignore", 8'h46, 1'b0, 1'b0, 3);
      @(posedge clk); #1;
      check("ignore.idle", 32'(busy), 32'd0);

      // 5: back-to-back start in the DONE cycle
      start_op(1'b1, 8'h40, 8'h40); finish_op("add40_40", 8'h80, 1'b0, 1'b1, -1);
      start_now(1'b1, 8'h10, 8'h20);
      finish_op("b2b", 8'h30, 1'b0, 1'b0, -1);

      // 6: reset mid-operation after four bits
      start_op(1'b1, 8'hF0, 8'h0F);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst.busy", 32'(busy),   32'd0);
      check("midrst.done", 32'(done),   32'd0);
      check("midrst.res",  32'(result), 32'd0);
      check("midrst.cout", 32'(cout),   32'd0);
      check("midrst.ovf",  32'(ovf),    32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst.nodone", 32'(done), 32'd0);
      @(negedge clk); rst = 1'b0;
      start_op(1'b1, 8'h0A, 8'h0B); finish_op("add0A_0B", 8'h15, 1'b0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
